// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end sharing one multi-cycle ALU between two requesters.
// Define ALU_ARB_TIMEOUT_EN to abort an operation after 16 BUSY cycles without alu_ack.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] b0,
    input  logic [31:0] b1,
    input  logic [8:0]  fnct0,
    input  logic [8:0]  fnct1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] res,
    output logic        cf,
    output logic        nf,
    output logic        zf,
    output logic        vf,
    output logic        busy,
    output logic        err,
    output logic [31:0] alu_inp_a,
    output logic [31:0] alu_inp_b,
    output logic [8:0]  alu_fnct_sel,
    input  logic [31:0] alu_out,
    input  logic        alu_cf,
    input  logic        alu_nf,
    input  logic        alu_zf,
    input  logic        alu_vf,
    input  logic        alu_ack
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [8:0] NOP  = 9'h100;

    logic [1:0]  r_state;
    logic        r_ptr;
    logic        r_id;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [8:0]  r_fnct;
    logic [31:0] r_res;
    logic        r_cf;
    logic        r_nf;
    logic        r_zf;
    logic        r_vf;
    logic        w_win1;
    logic        w_take;
    logic        w_in_busy;
    logic        w_abort;
    logic        w_fin;

    // r_ptr holds the last served requester; on contention the other one wins
    assign w_win1    = req1 & (~req0 | ~r_ptr);
    assign w_take    = (r_state == IDLE) & ~rst & (req0 | req1);
    assign w_in_busy = r_state == BUSY;
    assign w_fin     = w_in_busy & (alu_ack | w_abort);

    assign gnt0         = w_take & ~w_win1;
    assign gnt1         = w_take & w_win1;
    assign done0        = (r_state == RESP) & ~r_id;
    assign done1        = (r_state == RESP) & r_id;
    assign busy         = r_state != IDLE;
    assign alu_inp_a    = r_a;
    assign alu_inp_b    = r_b;
    assign alu_fnct_sel = w_in_busy ? r_fnct : NOP;
    assign res          = r_res;
    assign cf           = r_cf;
    assign nf           = r_nf;
    assign zf           = r_zf;
    assign vf           = r_vf;

`ifdef ALU_ARB_TIMEOUT_EN
    logic [4:0] r_cnt;
    logic       r_err;

    assign w_abort = w_in_busy & ~alu_ack & (r_cnt == 5'd15);
    assign err     = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 5'd0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_take ? 5'd0 : (w_in_busy & ~alu_ack) ? r_cnt + 5'd1 : r_cnt;
            r_err <= r_err | w_abort;
        end
    end
`else
    assign w_abort = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= 1'b1;
            r_id    <= 1'b0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_fnct  <= NOP;
            r_res   <= 32'd0;
            r_cf    <= 1'b0;
            r_nf    <= 1'b0;
            r_zf    <= 1'b0;
            r_vf    <= 1'b0;
        end else if (w_take) begin
            r_state <= BUSY;
            r_ptr   <= w_win1;
            r_id    <= w_win1;
            r_a     <= w_win1 ? a1 : a0;
            r_b     <= w_win1 ? b1 : b0;
            r_fnct  <= w_win1 ? fnct1 : fnct0;
        end else if (w_fin) begin
            // an aborted operation completes with a zero result and clear flags
            r_state <= RESP;
            r_res   <= alu_ack ? alu_out : 32'd0;
            r_cf    <= alu_ack & alu_cf;
            r_nf    <= alu_ack & alu_nf;
            r_zf    <= alu_ack & alu_zf;
            r_vf    <= alu_ack & alu_vf;
        end else if (r_state == RESP) begin
            r_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized scoreboard bench for alu_arbiter with a cycle-level reference model.
// Expectations for done/res/err follow ALU_ARB_TIMEOUT_EN when it is defined.
module tb_alu_arbiter;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [8:0]  f;
    } op_t;

    localparam int NOACK = 1000;
`ifdef ALU_ARB_TIMEOUT_EN
    localparam int TO_LAT = 17;
`else
    localparam int TO_LAT = 1000000;
`endif

    logic        clk = 0, rst = 1, req0 = 0, req1 = 0;
    logic [31:0] a0 = 0, a1 = 0, b0 = 0, b1 = 0;
    logic [8:0]  fnct0 = 0, fnct1 = 0;
    logic        gnt0, gnt1, done0, done1, cf, nf, zf, vf, busy, err;
    logic [31:0] res, alu_inp_a, alu_inp_b;
    logic [8:0]  alu_fnct_sel;
    logic [31:0] alu_out = 0;
    logic        alu_cf = 0, alu_nf = 0, alu_zf = 0, alu_vf = 0, alu_ack = 0;

    alu_arbiter dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .fnct0(fnct0), .fnct1(fnct1), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res(res), .cf(cf), .nf(nf), .zf(zf), .vf(vf), .busy(busy), .err(err),
        .alu_inp_a(alu_inp_a), .alu_inp_b(alu_inp_b), .alu_fnct_sel(alu_fnct_sel),
        .alu_out(alu_out), .alu_cf(alu_cf), .alu_nf(alu_nf), .alu_zf(alu_zf), .alu_vf(alu_vf),
        .alu_ack(alu_ack)
    );

    int  checks = 0, errors = 0, cyc = 0;
    op_t q0[$], q1[$];
    int  glog[$];
    int  gcount[2] = '{0, 0}, consumed[2] = '{0, 0}, want[2] = '{0, 0};
    int  gcyc = -100, done_cyc = -1, free_cyc = 0, cur_d = 1, next_d = 0, fix_r = 0;
    bit  owner = 0, m_last = 1, m_err = 0, raise_now = 0, wd_en = 0, fix_v = 0;
    logic [35:0] m_out = 0;
    op_t fix;

    initial forever #5 clk = ~clk;
    initial forever @(posedge clk) cyc++;
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // external ALU behaviour: {vf, zf, nf, cf, result}
    function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [8:0] f);
        logic [31:0] r;
        r = f[6] ? a + b : (a ^ b) + {23'd0, f};
        return {b[0] ^ f[0], r == 32'd0, r[31], ^a, r};
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic issue(input int r);
        op_t o;
        o.a = $urandom;
        o.b = $urandom;
        o.f = 9'($urandom);
        if (fix_v && fix_r == r) o = fix;
        if (r == 0) begin
            a0 = o.a; b0 = o.b; fnct0 = o.f; req0 = 1; q0.push_back(o);
        end else begin
            a1 = o.a; b1 = o.b; fnct1 = o.f; req1 = 1; q1.push_back(o);
        end
        want[r]--;
    endtask

    task automatic step_req(input int r);
        logic held;
        held = (r == 0) ? req0 : req1;
        if (gcount[r] != consumed[r]) begin
            consumed[r] = gcount[r];
            if (want[r] > 0) issue(r);
            else if (r == 0) req0 = 0;
            else req1 = 0;
        end else if (held) begin
            if (wd_en && $urandom % 8 == 0) begin
                if (r == 0) begin req0 = 0; void'(q0.pop_back()); end
                else begin req1 = 0; void'(q1.pop_back()); end
                want[r]++;
            end
        end else if (want[r] > 0 && (raise_now || $urandom % 3 == 0)) begin
            issue(r);
        end
    endtask

    task automatic tick();
        logic [35:0] o;
        @(posedge clk);
        #1;
        if (rst) begin
            alu_ack = 0;
        end else begin
            step_req(0);
            step_req(1);
            if (cyc > gcyc && cyc < done_cyc) begin
                alu_ack = 0;
                if (cur_d != NOACK && cyc - gcyc == cur_d) begin
                    o = ref_alu(alu_inp_a, alu_inp_b, alu_fnct_sel);
                    alu_ack = 1;
                    alu_out = o[31:0];
                    {alu_vf, alu_zf, alu_nf, alu_cf} = o[35:32];
                end
            end else begin
                // stray acks outside BUSY must be ignored
                alu_ack = ($urandom % 3 == 0);
                alu_out = $urandom;
                {alu_vf, alu_zf, alu_nf, alu_cf} = 4'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 1; req0 = 0; req1 = 0; want[0] = 0; want[1] = 0; alu_ack = 0;
        repeat (2) tick();
        consumed[0] = gcount[0];
        consumed[1] = gcount[1];
        rst = 0;
    endtask

    task automatic wait_done(input string nm, input int maxc);
        int n;
        n = 0;
        while (!(want[0] == 0 && want[1] == 0 && !req0 && !req1 && q0.size() == 0 &&
                 q1.size() == 0 && cyc >= free_cyc) && n < maxc) begin
            tick();
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL wait_%s: traffic not drained within %0d cycles", nm, maxc);
        end
    endtask

    // monitor: reference model of arbitration/latency plus scoreboard pops on done
    initial begin
        bit  idle, any, w, inb;
        op_t o;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_busy", busy, 0);
                chk("rst_sel", alu_fnct_sel, 9'h100);
                chk("rst_res", res, 0);
                chk("rst_flags", {cf, nf, zf, vf}, 0);
                chk("rst_gnt", {gnt0, gnt1}, 0);
                chk("rst_done", {done0, done1}, 0);
                chk("rst_err", err, 0);
                chk("rst_inp", {alu_inp_a, alu_inp_b}, 0);
                gcyc = -100; done_cyc = -1; free_cyc = 0; m_last = 1; m_out = 0; m_err = 0;
                q0.delete();
                q1.delete();
            end else begin
                idle = cyc >= free_cyc;
                any  = req0 | req1;
                w    = (req0 && req1) ? !m_last : req1;
                if (cyc == done_cyc) begin
                    if ((owner ? q1.size() : q0.size()) == 0) begin
                        chk("sb_empty", {done0, done1}, 0);
                    end else begin
                        o = owner ? q1.pop_front() : q0.pop_front();
                        m_out = (cur_d == NOACK) ? 36'd0 : ref_alu(o.a, o.b, o.f);
                        if (cur_d == NOACK) m_err = 1;
                    end
                end
                chk("done0", done0, cyc == done_cyc && owner == 0);
                chk("done1", done1, cyc == done_cyc && owner == 1);
                chk("res", res, m_out[31:0]);
                chk("flags_vznc", {vf, zf, nf, cf}, m_out[35:32]);
                chk("err", err, m_err);
                chk("busy", busy, !idle);
                inb = cyc > gcyc && cyc < done_cyc;
                if (inb && (owner ? q1.size() : q0.size()) != 0) begin
                    o = owner ? q1[0] : q0[0];
                    chk("alu_sel", alu_fnct_sel, o.f);
                    chk("alu_a", alu_inp_a, o.a);
                    chk("alu_b", alu_inp_b, o.b);
                end else if (!inb) begin
                    chk("alu_sel_nop", alu_fnct_sel, 9'h100);
                end
                chk("gnt0", gnt0, idle && any && !w);
                chk("gnt1", gnt1, idle && any && w);
                if (idle && any) begin
                    owner = w;
                    m_last = w;
                    gcount[w]++;
                    glog.push_back(int'(w));
                    gcyc = cyc;
                    cur_d = (next_d == 0) ? int'($urandom_range(1, 4)) : next_d;
                    done_cyc = cyc + ((cur_d == NOACK) ? TO_LAT : cur_d + 1);
                    free_cyc = done_cyc + 1;
                end
            end
        end
    end

    initial begin
        int base, g, n;
        repeat (3) tick();
        rst = 0;
        // single request with fixed operands and ack two cycles into BUSY
        fix = '{a: 32'h8, b: 32'h4, f: 9'b001000000};
        fix_v = 1; fix_r = 0; next_d = 2; raise_now = 1; want[0] = 1;
        wait_done("single", 40);
        chk("single_res", res, 32'hC);
        chk("single_zf", zf, 0);
        fix_v = 0; next_d = 0;
        // contention right after reset: requester 0 first
        do_reset();
        base = glog.size();
        want[0] = 1; want[1] = 1;
        wait_done("contention", 60);
        chk("cont_count", glog.size() - base, 2);
        if (glog.size() >= base + 2) begin
            chk("cont_first", glog[base], 0);
            chk("cont_second", glog[base + 1], 1);
        end
        // fairness: both held continuously for six operations
        base = glog.size();
        want[0] = 3; want[1] = 3;
        wait_done("fair", 150);
        chk("fair_count", glog.size() - base, 6);
        for (int i = 0; i < 6 && base + i < glog.size(); i++) chk("fair_order", glog[base + i], i % 2);
        // random traffic with withdrawals
        raise_now = 0; wd_en = 1; want[0] = 12; want[1] = 12;
        wait_done("random", 3000);
        wd_en = 0; raise_now = 1;
        // reset while BUSY, then a normal request
        next_d = 10;
        g = gcount[0];
        want[0] = 1;
        n = 0;
        while (gcount[0] == g && n < 50) begin tick(); n++; end
        chk("midrst_granted", gcount[0] - g, 1);
        repeat (2) tick();
        do_reset();
        repeat (4) tick();
        next_d = 0;
        want[0] = 1;
        wait_done("post_reset", 40);
        // ALU never acknowledges a requester 1 operation
        next_d = NOACK;
        want[1] = 1;
`ifdef ALU_ARB_TIMEOUT_EN
        wait_done("timeout", 60);
        repeat (5) tick();
        chk("to_err_held", err, 1);
        chk("to_res", res, 0);
`else
        repeat (30) tick();
        chk("noto_busy", busy, 1);
        chk("noto_err", err, 0);
        do_reset();
`endif
        next_d = 0;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
